ring_mem_responder: RTL and testbench
=====================================

Name: ring_mem_responder

Overview:
- Memory-side station on the cache ring; it is the responder end of the cache miss/flush protocol.
- Consumes Address and WriteData slots that caches place on the ring and queues them as line requests to a line-oriented memory backend.
- Returns each read line as 8 consecutive-order words on the read-data return ring (RDreturn/RDdest), tagged with the requesting core.
- Sits on the ring between the last core and the ring head, next to the memory controller.

Parameters:
CMD_DEPTH, 8, command FIFO entries (power of 2); each entry holds {isWrite, src[3:0], lineAddr[27:0]}
WD_DEPTH, 16, write-data FIFO words (power of 2, >= 8)
IDLE_DEST, 4'd0, RDdest value driven when no read data is returned; cores are numbered 1..14

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
RingIn  in  32  ring data in
SlotTypeIn  in  4  slot type in (Token=1, Address=2, WriteData=3, Null=7)
SrcDestIn  in  4  slot source core
RingOut  out  32  ring data out
SlotTypeOut  out  4  slot type out
SrcDestOut  out  4  source out
RDreturn  out  32  read-return data
RDdest  out  4  read-return destination core
memReq  out  1  line request valid
memWrite  out  1  1 = write line, 0 = read line (valid with memReq)
memAddr  out  28  line address (byte address [30:3])
memAck  in  1  backend accepts request this cycle
memWD  out  32  write word
memWDvalid  out  1  write word valid
memRD  in  32  read word from backend
memRDvalid  in  1  read word valid
overflow  out  1  sticky: command or write-data FIFO overflowed
protoErr  out  1  sticky: write command found fewer than 8 buffered words

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset state:
  - FSM to IDLE; both FIFOs empty; overflow = 0; protoErr = 0.
  - memReq, memWDvalid = 0.
  - RDdest = IDLE_DEST; RDreturn = 0.
- Ring decode is combinational and same-cycle. Any slot not consumed passes through unchanged: RingOut = RingIn, SlotTypeOut = SlotTypeIn, SrcDestOut = SrcDestIn. Tokens are never modified.
- Read address: SlotTypeIn == 2 and RingIn[31:28] is 4'b0001 or 4'b0011 (I/D flag is bit 29; it is ignored).
  - Push {0, SrcDestIn, RingIn[27:0]} to the command FIFO.
- Write address: SlotTypeIn == 2 and RingIn[31:28] == 4'b0000.
  - Push {1, SrcDestIn, RingIn[27:0]} to the command FIFO.
- Write data: SlotTypeIn == 3. Push RingIn to the write-data FIFO.
- Consumed slots are replaced on the output by SlotTypeOut = 7, RingOut = 0, SrcDestOut = SrcDestIn.
- Address slots with any other RingIn[31:28] value are not consumed.
- Pushes into a full FIFO: the item is dropped, the slot is still nulled, and overflow is set.
- Write data precedes its write address on the ring. Words of one line are FIFO-consecutive.
- FSM states:
  - IDLE:
    - If the command FIFO is non-empty and the head is a write with WD count < 8: pop the head, set protoErr, stay in IDLE.
    - Otherwise, if the command FIFO is non-empty: go to ISSUE.
  - ISSUE:
    - memReq = 1, with memWrite and memAddr taken from the head.
    - On memAck: pop the head; go to WDATA if it is a write, else RWAIT.
  - WDATA:
    - 8 cycles; each cycle pop one WD word onto memWD with memWDvalid = 1.
    - 3-bit counter; after the word with count 7, go to IDLE.
  - RWAIT:
    - Each memRDvalid word is registered: RDreturn <= memRD and RDdest <= latched src in the next cycle. Otherwise RDdest <= IDLE_DEST.
    - Gaps between words are allowed.
    - After the 8th word, go to IDLE.
- One outstanding backend request at a time; commands complete strictly in ring-arrival order.
- Simultaneous ring push and FSM pop on the same FIFO are legal, including when the FIFO is full: the pop frees the slot, so no overflow.
- FIFO pointers wrap modulo depth. The count is held 1 bit wider than the pointer.
- memRDvalid outside RWAIT is ignored.
- Reset mid-transfer aborts the transfer: FIFO contents are discarded and RDdest returns to IDLE_DEST on the next cycle.
- Minimum read latency: the ring slot at cycle t gives memReq at t+2 (push t, IDLE t+1, ISSUE t+2).

Test Plan:
- Read address slot 0x1000_0040 from src 3; backend acks and returns words 0xA0..0xA7 back-to-back -> memAddr = 0x0000040, memWrite = 0, RDdest = 3 with RDreturn = 0xA0..0xA7 over 8 cycles, then RDdest = 0; slot leaves as Null.
- Dirty miss train from src 5: RA 0x1000_0100, WD 0x11..0x18, WA 0x0000_0200 -> read of 0x100 issued first, then write of 0x200 with memWD = 0x11..0x18 in order.
- Flush-only train: WD 0x1..0x8 then WA 0x0ABC_DEF0 -> one write, memAddr = 0xABCDEF0; protoErr stays 0.
- Write address with only 3 buffered words -> command dropped, protoErr = 1, no memReq.
- 9 read addresses on consecutive cycles with memAck held low -> 9th dropped, overflow = 1; first 8 are served in order once memAck rises.
- Token 0x0000_000A and an Address slot with top nibble 0x4 -> both pass through unchanged.

Source files
------------

// File: rtl/ring_mem_responder.sv
// ring_mem_responder: memory-side ring station that turns miss/flush slots into line requests and returns read lines.
module ring_mem_responder #(
  parameter int CMD_DEPTH = 8,
  parameter int WD_DEPTH = 16,
  parameter logic [3:0] IDLE_DEST = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SrcDestIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SrcDestOut,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        memReq,
  output logic        memWrite,
  output logic [27:0] memAddr,
  input  logic        memAck,
  output logic [31:0] memWD,
  output logic        memWDvalid,
  input  logic [31:0] memRD,
  input  logic        memRDvalid,
  output logic        overflow,
  output logic        protoErr
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int WW = $clog2(WD_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WDATA = 2'd2, RWAIT = 2'd3;
  logic [32:0] cmdMem [CMD_DEPTH];
  logic [CW-1:0] cmdWr, cmdRd;
  logic [CW:0] cmdCount;
  logic [31:0] wdMem [WD_DEPTH];
  logic [WW-1:0] wdWr, wdRd;
  logic [WW:0] wdCount;
  logic [1:0] state, nextState;
  logic [2:0] beat;
  logic [3:0] curSrc;
  logic [32:0] cmdHead;
  logic isAddr, rdAddr, wrAddr, cmdPush, wdPush, consume;
  logic cmdEmpty, headWrite, protoDrop, cmdPop, wdPop, cmdPushOk, wdPushOk;
  always_comb begin
    isAddr = SlotTypeIn == 4'd2;
    rdAddr = isAddr && (RingIn[31:28] == 4'b0001 || RingIn[31:28] == 4'b0011);
    wrAddr = isAddr && RingIn[31:28] == 4'b0000;
    cmdPush = rdAddr || wrAddr;
    wdPush = SlotTypeIn == 4'd3;
    consume = cmdPush || wdPush;
    cmdHead = cmdMem[cmdRd];
    cmdEmpty = cmdCount == '0;
    headWrite = cmdHead[32];
    protoDrop = state == IDLE && !cmdEmpty && headWrite && wdCount < (WW+1)'(8);
    cmdPop = protoDrop || (state == ISSUE && memAck);
    wdPop = state == WDATA;
    // a same-cycle pop frees a slot, so a push into a full FIFO is still accepted
    cmdPushOk = cmdPush && (cmdCount != (CW+1)'(CMD_DEPTH) || cmdPop);
    wdPushOk = wdPush && (wdCount != (WW+1)'(WD_DEPTH) || wdPop);
    nextState = state == IDLE  ? (!cmdEmpty && !protoDrop ? ISSUE : IDLE)
              : state == ISSUE ? (memAck ? (headWrite ? WDATA : RWAIT) : ISSUE)
              : state == WDATA ? (beat == 3'd7 ? IDLE : WDATA)
              : (memRDvalid && beat == 3'd7 ? IDLE : RWAIT);
  end
  assign RingOut = consume ? 32'd0 : RingIn;
  assign SlotTypeOut = consume ? 4'd7 : SlotTypeIn;
  assign SrcDestOut = SrcDestIn;
  assign memReq = state == ISSUE;
  assign memWrite = headWrite;
  assign memAddr = cmdHead[27:0];
  assign memWD = wdMem[wdRd];
  assign memWDvalid = state == WDATA;
  always_ff @(posedge clock) begin
    if (cmdPushOk) cmdMem[cmdWr] <= {wrAddr, SrcDestIn, RingIn[27:0]};
    if (wdPushOk) wdMem[wdWr] <= RingIn;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cmdWr <= '0;
      cmdRd <= '0;
      cmdCount <= '0;
      wdWr <= '0;
      wdRd <= '0;
      wdCount <= '0;
      state <= IDLE;
      beat <= '0;
      curSrc <= '0;
      overflow <= 1'b0;
      protoErr <= 1'b0;
      RDdest <= IDLE_DEST;
      RDreturn <= '0;
    end else begin
      if (cmdPushOk) cmdWr <= cmdWr + 1'b1;
      if (cmdPop) cmdRd <= cmdRd + 1'b1;
      cmdCount <= cmdCount + (CW+1)'(cmdPushOk) - (CW+1)'(cmdPop);
      if (wdPushOk) wdWr <= wdWr + 1'b1;
      if (wdPop) wdRd <= wdRd + 1'b1;
      wdCount <= wdCount + (WW+1)'(wdPushOk) - (WW+1)'(wdPop);
      if ((cmdPush && !cmdPushOk) || (wdPush && !wdPushOk)) overflow <= 1'b1;
      if (protoDrop) protoErr <= 1'b1;
      if (state == ISSUE && memAck) curSrc <= cmdHead[31:28];
      if (state == WDATA || (state == RWAIT && memRDvalid)) beat <= beat + 1'b1;
      RDdest <= IDLE_DEST;
      if (state == RWAIT && memRDvalid) begin
        RDreturn <= memRD;
        RDdest <= curSrc;
      end
      state <= nextState;
    end
  end
endmodule

// File: tb/tb_ring_mem_responder.sv
// tb_ring_mem_responder: directed ring traffic with a queue scoreboard checked by a separate output monitor.
module tb_ring_mem_responder;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] RingIn, RingOut, RDreturn, memWD, memRD;
  logic [3:0] SlotTypeIn, SrcDestIn, SlotTypeOut, SrcDestOut, RDdest;
  logic memReq, memWrite, memAck, memWDvalid, memRDvalid, overflow, protoErr;
  logic [27:0] memAddr;
  int passCount = 0, totalCount = 0;
  logic [28:0] expReq [$];
  logic [31:0] expWD [$];
  logic [35:0] expRD [$];
  logic [31:0] rdQ [$];
  bit ackEnable = 0, gapMode = 0, gapTog = 1;
  int readLeft = 0;

  ring_mem_responder dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SrcDestOut(SrcDestOut),
    .RDreturn(RDreturn), .RDdest(RDdest), .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
    .memAck(memAck), .memWD(memWD), .memWDvalid(memWDvalid), .memRD(memRD), .memRDvalid(memRDvalid),
    .overflow(overflow), .protoErr(protoErr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic failNote(input string name, input logic [63:0] act);
    totalCount++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (memReq && memAck) begin
        if (expReq.size() == 0) failNote("unexpected memReq", {memWrite, memAddr});
        else check("memReq", {memWrite, memAddr}, expReq.pop_front());
      end
      if (memWDvalid) begin
        if (expWD.size() == 0) failNote("unexpected memWD", memWD);
        else check("memWD", memWD, expWD.pop_front());
      end
      if (RDdest != 4'd0) begin
        if (expRD.size() == 0) failNote("unexpected RDreturn", {RDdest, RDreturn});
        else check("RDreturn", {RDdest, RDreturn}, expRD.pop_front());
      end
    end
  end

  initial begin
    memAck = 0;
    memRDvalid = 0;
    memRD = 0;
    forever begin
      @(posedge clock);
      #2;
      memAck = 0;
      memRDvalid = 0;
      if (readLeft > 0) begin
        if (gapMode && gapTog) gapTog = 0;
        else begin
          gapTog = 1;
          memRDvalid = 1;
          memRD = rdQ.size() > 0 ? rdQ.pop_front() : 32'hDEAD_BEEF;
          readLeft--;
        end
      end
      if (memReq && ackEnable && readLeft == 0) begin
        memAck = 1;
        if (!memWrite) readLeft = 8;
      end
    end
  end

  task automatic ringSlot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s, input bit consumed, input string name);
    @(posedge clock);
    #1;
    SlotTypeIn = t;
    RingIn = d;
    SrcDestIn = s;
    #1;
    check(name, {SlotTypeOut, RingOut, SrcDestOut}, consumed ? {4'd7, 32'd0, s} : {t, d, s});
  endtask

  task automatic ringIdle();
    @(posedge clock);
    #1;
    SlotTypeIn = 4'd7;
    RingIn = '0;
    SrcDestIn = '0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clock);
      done = expReq.size() == 0 && expWD.size() == 0 && expRD.size() == 0 && readLeft == 0;
    end
    if (!done) failNote({name, " drain timeout"}, 64'(expReq.size() + expWD.size() + expRD.size()));
    repeat (12) @(posedge clock);
  endtask

  task automatic readLine(input logic [3:0] src, input logic [27:0] addr, input logic [31:0] base);
    expReq.push_back({1'b0, addr});
    for (int j = 0; j < 8; j++) begin
      rdQ.push_back(base + 32'(j));
      expRD.push_back({src, base + 32'(j)});
    end
  endtask

  initial begin
    reset = 1;
    RingIn = '0;
    SlotTypeIn = 4'd7;
    SrcDestIn = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset memReq", memReq, 0);
    check("reset memWDvalid", memWDvalid, 0);
    check("reset RDdest", RDdest, 0);
    check("reset RDreturn", RDreturn, 0);
    check("reset overflow", overflow, 0);
    check("reset protoErr", protoErr, 0);
    @(posedge clock);
    #1 reset = 0;

    ackEnable = 1;
    readLine(4'd3, 28'h0000040, 32'hA0);
    ringSlot(4'd2, 32'h1000_0040, 4'd3, 1, "read slot nulled");
    ringIdle();
    drain("single read");

    gapMode = 1;
    readLine(4'd5, 28'h0000100, 32'hB0);
    ringSlot(4'd2, 32'h1000_0100, 4'd5, 1, "dirty RA nulled");
    for (int j = 0; j < 8; j++) begin
      expWD.push_back(32'h11 + 32'(j));
      ringSlot(4'd3, 32'h11 + 32'(j), 4'd5, 1, "dirty WD nulled");
    end
    expReq.push_back({1'b1, 28'h0000200});
    ringSlot(4'd2, 32'h0000_0200, 4'd5, 1, "dirty WA nulled");
    ringIdle();
    drain("dirty miss");
    gapMode = 0;

    for (int j = 0; j < 8; j++) begin
      expWD.push_back(32'h1 + 32'(j));
      ringSlot(4'd3, 32'h1 + 32'(j), 4'd2, 1, "flush WD nulled");
    end
    expReq.push_back({1'b1, 28'hABCDEF0});
    ringSlot(4'd2, 32'h0ABC_DEF0, 4'd2, 1, "flush WA nulled");
    ringIdle();
    drain("flush");
    check("flush protoErr", protoErr, 0);

    for (int j = 0; j < 3; j++) ringSlot(4'd3, 32'h21 + 32'(j), 4'd4, 1, "short WD nulled");
    ringSlot(4'd2, 32'h0000_0300, 4'd4, 1, "short WA nulled");
    ringIdle();
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("short write protoErr", protoErr, 1);
    check("short write overflow", overflow, 0);
    @(posedge clock);
    #1 reset = 1;
    @(posedge clock);
    @(negedge clock);
    check("reset clears protoErr", protoErr, 0);
    @(posedge clock);
    #1 reset = 0;

    ackEnable = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) readLine(4'(i + 1), 28'(i * 32'h40), 32'hC000_0000 + 32'(i * 16));
      ringSlot(4'd2, 32'h1000_0000 + 32'(i * 32'h40), 4'(i + 1), 1, "burst RA nulled");
    end
    ringIdle();
    @(negedge clock);
    check("burst overflow", overflow, 1);
    ackEnable = 1;
    drain("burst");

    ringSlot(4'd1, 32'h0000_000A, 4'd6, 0, "token passthrough");
    ringSlot(4'd2, 32'h4000_1234, 4'd7, 0, "odd address passthrough");
    ringIdle();
    drain("passthrough");
    check("leftover read words", 64'(rdQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global timeout: %0d/%0d checks passed", passCount, totalCount);
    $fatal(1);
  end
endmodule
